// File: rtl/abc_pkg.sv
// -----------------------------------------------------------------------------
// abc_pkg
// Shared types for the ABC egress packet buffer.
//   ABC_DATA_W   : payload byte width
//   abc_entry_t  : one buffer entry {eop, qos, data}
//   abc_ing_st_e : ingress framing FSM states
// -----------------------------------------------------------------------------
package abc_pkg;

    localparam int ABC_DATA_W = 8;

    typedef struct packed {
        logic                  eop;
        logic                  qos;
        logic [ABC_DATA_W-1:0] data;
    } abc_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } abc_ing_st_e;

endpackage

// File: rtl/abc_pkt_ram.sv
// -----------------------------------------------------------------------------
// abc_pkt_ram
// DEPTH x abc_entry_t register array: one synchronous write port and one
// asynchronous (combinational) read port.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write entry
//   raddr  : read address
//   rdata  : entry at raddr, same cycle
// -----------------------------------------------------------------------------
module abc_pkt_ram
    import abc_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  abc_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output abc_entry_t    rdata
);

    abc_entry_t mem [DEPTH];

    // NOTE: the storage array is deliberately left without reset; the pointers
    // alone decide which entries are meaningful, so resetting data buys nothing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/abc_egress_pkt_buffer.sv
// -----------------------------------------------------------------------------
// abc_egress_pkt_buffer
// Store-and-forward packet buffer for one ABC_TOP output channel. Bytes are
// written tentatively at wr_ptr and become visible to the sink only when the
// packet's eop moves cm_ptr forward. Malformed, oversize and overflowing
// packets are rewound (wr_ptr <= cm_ptr) and counted.
//   clk, rst_n                      : clock, async active-low reset
//   in_data/sop/eop/qos/vld         : unbackpressured ingress byte stream
//   out_data/sop/eop/qos/valid      : FWFT head of committed data
//   out_ready                       : sink accept
//   pkt_ok_cnt / pkt_drop_cnt       : saturating packet statistics
//   orphan_err                      : 1-cycle pulse for a byte outside a packet
// -----------------------------------------------------------------------------
module abc_egress_pkt_buffer
    import abc_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ABC_DATA_W-1:0] in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic                  in_qos,
    input  logic                  in_vld,
    output logic [ABC_DATA_W-1:0] out_data,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  out_qos,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      pkt_ok_cnt,
    output logic [CNT_W-1:0]      pkt_drop_cnt,
    output logic                  orphan_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int ADDR_W = AW + 1;
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [LEN_W-1:0]  MAX_LEN_L = LEN_W'(MAX_LEN);

    abc_ing_st_e       st, st_nxt;
    logic [ADDR_W-1:0] wr_ptr, cm_ptr, rd_ptr;
    logic [ADDR_W-1:0] wr_nxt, cm_nxt;
    logic [LEN_W-1:0]  len, len_nxt;
    logic              qos_q, qos_nxt;
    logic              sop_pend;
    logic              orphan_nxt;

    logic              we;
    logic [AW-1:0]     waddr;
    abc_entry_t        wdata;
    abc_entry_t        head;

    logic              ok_inc;
    logic [1:0]        drop_inc;
    logic [CNT_W:0]    ok_sum, drop_sum;
    logic [CNT_W-1:0]  ok_nxt, drop_nxt;

    logic              wr_full, cm_full, xfer;

    // Both use rd_ptr before any same-cycle read, so a read never frees space
    // in the cycle it happens. cm_full is the space seen by a new sop, which
    // always starts at cm_ptr (an in-flight packet it aborts is rewound).
    assign wr_full = (wr_ptr - rd_ptr) == DEPTH_A;
    assign cm_full = (cm_ptr - rd_ptr) == DEPTH_A;

    abc_pkt_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    // ------------------------------------------------------------------ egress
    assign out_valid = (rd_ptr != cm_ptr);
    assign xfer      = out_valid & out_ready;
    assign out_data  = out_valid ? head.data : '0;
    assign out_eop   = out_valid & head.eop;
    assign out_qos   = out_valid & head.qos;
    assign out_sop   = out_valid & sop_pend;

    // ------------------------------------------------------------ ingress FSM
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case logic can leave one unassigned and infer a latch.
    always_comb begin
        st_nxt     = st;
        wr_nxt     = wr_ptr;
        cm_nxt     = cm_ptr;
        len_nxt    = len;
        qos_nxt    = qos_q;
        we         = 1'b0;
        waddr      = wr_ptr[AW-1:0];
        wdata      = '{eop: in_eop, qos: qos_q, data: in_data};
        ok_inc     = 1'b0;
        drop_inc   = 2'd0;
        orphan_nxt = 1'b0;

        if (in_vld) begin
            if (in_sop) begin
                // A sop mid-packet aborts the packet in flight; the new sop is
                // then handled exactly as from IDLE, based at cm_ptr.
                if (st == RECV) begin
                    drop_inc = drop_inc + 2'd1;
                end
                wr_nxt = cm_ptr;
                if (cm_full) begin
                    drop_inc = drop_inc + 2'd1;
                    st_nxt   = in_eop ? IDLE : DROP;
                end else begin
                    we        = 1'b1;
                    waddr     = cm_ptr[AW-1:0];
                    wdata.qos = in_qos;
                    qos_nxt   = in_qos;
                    len_nxt   = LEN_W'(1);
                    wr_nxt    = cm_ptr + 1'b1;
                    if (in_eop) begin
                        cm_nxt = cm_ptr + 1'b1;
                        ok_inc = 1'b1;
                        st_nxt = IDLE;
                    end else begin
                        st_nxt = RECV;
                    end
                end
            end else begin
                case (st)
                    IDLE: orphan_nxt = 1'b1;
                    RECV: begin
                        if (wr_full || len == MAX_LEN_L) begin
                            wr_nxt   = cm_ptr;
                            drop_inc = 2'd1;
                            st_nxt   = in_eop ? IDLE : DROP;
                        end else begin
                            we      = 1'b1;
                            wr_nxt  = wr_ptr + 1'b1;
                            len_nxt = len + 1'b1;
                            if (in_eop) begin
                                cm_nxt = wr_ptr + 1'b1;
                                ok_inc = 1'b1;
                                st_nxt = IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (in_eop) begin
                            st_nxt = IDLE;
                        end
                    end
                    default: st_nxt = IDLE;
                endcase
            end
        end

        // Saturating counters: the carry-out bit flags an overflow.
        ok_sum   = {1'b0, pkt_ok_cnt} + (CNT_W+1)'(ok_inc);
        drop_sum = {1'b0, pkt_drop_cnt} + (CNT_W+1)'(drop_inc);
        ok_nxt   = ok_sum[CNT_W]   ? '1 : ok_sum[CNT_W-1:0];
        drop_nxt = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= IDLE;
            wr_ptr       <= '0;
            cm_ptr       <= '0;
            rd_ptr       <= '0;
            len          <= '0;
            qos_q        <= 1'b0;
            sop_pend     <= 1'b1;
            orphan_err   <= 1'b0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            st           <= st_nxt;
            wr_ptr       <= wr_nxt;
            cm_ptr       <= cm_nxt;
            rd_ptr       <= rd_ptr + ADDR_W'(xfer);
            len          <= len_nxt;
            qos_q        <= qos_nxt;
            orphan_err   <= orphan_nxt;
            pkt_ok_cnt   <= ok_nxt;
            pkt_drop_cnt <= drop_nxt;
            if (xfer) begin
                // The byte after an eop is the next packet's first byte.
                sop_pend <= head.eop;
            end
        end
    end

endmodule

// File: tb/tb_abc_egress_pkt_buffer.sv
module tb_abc_egress_pkt_buffer;

    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_sop = 1'b0, in_eop = 1'b0, in_qos = 1'b0, in_vld = 1'b0;
    logic [7:0]       out_data;
    logic             out_sop, out_eop, out_qos, out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] pkt_ok_cnt, pkt_drop_cnt;
    logic             orphan_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    abc_egress_pkt_buffer #(.DEPTH(DEPTH), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_qos       (in_qos),
        .in_vld       (in_vld),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_qos      (out_qos),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pkt_ok_cnt   (pkt_ok_cnt),
        .pkt_drop_cnt (pkt_drop_cnt),
        .orphan_err   (orphan_err)
    );

    // ------------------------------------------------------ reference model
    // Packet-level view: cq holds bytes the sink may see, pq the packet being
    // received. Each byte carries its own "first of packet" flag.
    typedef struct {
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       qos;
    } mbyte_t;

    mbyte_t cq[$];
    mbyte_t pq[$];
    bit     in_pkt, dropping, m_orphan, cur_qos;
    int     m_ok, m_drop;

    function automatic int sat(input int v);
        return (v > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v;
    endfunction

    task automatic model_reset();
        cq.delete(); pq.delete();
        in_pkt = 0; dropping = 0; m_orphan = 0; cur_qos = 0;
        m_ok = 0; m_drop = 0;
    endtask

    task automatic model_commit();
        foreach (pq[i]) cq.push_back(pq[i]);
        pq.delete();
        m_ok++;
        in_pkt = 0;
    endtask

    task automatic model_step(input bit vld, sop, eop, qos, input logic [7:0] d, input bit rdy);
        bit     rd;
        mbyte_t b;
        rd       = rdy && (cq.size() != 0);
        m_orphan = 0;
        if (vld) begin
            if (sop) begin
                if (in_pkt) begin
                    m_drop++;
                    pq.delete();
                    in_pkt = 0;
                end
                dropping = 0;
                if (cq.size() == DEPTH) begin
                    m_drop++;
                    dropping = !eop;
                end else begin
                    b = '{d, 1'b1, eop, qos};
                    pq.push_back(b);
                    cur_qos = qos;
                    if (eop) model_commit();
                    else     in_pkt = 1;
                end
            end else if (in_pkt) begin
                if (cq.size() + pq.size() == DEPTH || pq.size() == MAX_LEN) begin
                    m_drop++;
                    pq.delete();
                    in_pkt   = 0;
                    dropping = !eop;
                end else begin
                    b = '{d, 1'b0, eop, cur_qos};
                    pq.push_back(b);
                    if (eop) model_commit();
                end
            end else if (dropping) begin
                if (eop) dropping = 0;
            end else begin
                m_orphan = 1;
            end
        end
        if (rd) void'(cq.pop_front());
    endtask

    // One clock: drive inputs at negedge, sample 1 time unit after posedge,
    // advance the model and compare every observable output.
    task automatic step(input bit vld, sop, eop, qos, input logic [7:0] d, input bit rdy);
        logic [10:0] exp_head;
        @(negedge clk);
        in_vld = vld; in_sop = sop; in_eop = eop; in_qos = qos; in_data = d; out_ready = rdy;
        @(posedge clk);
        #1;
        model_step(vld, sop, eop, qos, d, rdy);
        n_checks++;
        if (out_valid !== (cq.size() != 0)) begin
            n_fail++;
            $display("FAIL out_valid @%0t: got %b want %b", $time, out_valid, cq.size() != 0);
        end
        if (cq.size() != 0) begin
            exp_head = {cq[0].data, cq[0].sop, cq[0].eop, cq[0].qos};
            n_checks++;
            if ({out_data, out_sop, out_eop, out_qos} !== exp_head) begin
                n_fail++;
                $display("FAIL head{data,sop,eop,qos} @%0t: got %h want %h", $time,
                         {out_data, out_sop, out_eop, out_qos}, exp_head);
            end
        end
        n_checks++;
        if (pkt_ok_cnt !== CNT_W'(sat(m_ok))) begin
            n_fail++;
            $display("FAIL pkt_ok_cnt @%0t: got %0d want %0d", $time, pkt_ok_cnt, sat(m_ok));
        end
        n_checks++;
        if (pkt_drop_cnt !== CNT_W'(sat(m_drop))) begin
            n_fail++;
            $display("FAIL pkt_drop_cnt @%0t: got %0d want %0d", $time, pkt_drop_cnt, sat(m_drop));
        end
        n_checks++;
        if (orphan_err !== m_orphan) begin
            n_fail++;
            $display("FAIL orphan_err @%0t: got %b want %b", $time, orphan_err, m_orphan);
        end
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, rdy);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({out_valid, out_sop, out_eop, out_qos, out_data, pkt_ok_cnt, pkt_drop_cnt, orphan_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b s=%b e=%b q=%b d=%h ok=%0d drop=%0d orph=%b want all 0",
                     out_valid, out_sop, out_eop, out_qos, out_data, pkt_ok_cnt, pkt_drop_cnt, orphan_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_packet();
        step(1, 1, 0, 1, 8'hA1, 1);
        step(1, 0, 0, 0, 8'hA2, 1);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_early_valid: got %b want 0", out_valid);
        end
        step(1, 0, 1, 0, 8'hA3, 1);
        n_checks++;
        if ({out_valid, out_data, out_sop, out_eop, out_qos} !== {1'b1, 8'hA1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_byte1: got v=%b d=%h s=%b e=%b q=%b want 1 a1 1 0 1",
                     out_valid, out_data, out_sop, out_eop, out_qos);
        end
        idle(1);
        n_checks++;
        if ({out_data, out_sop, out_eop, out_qos} !== {8'hA2, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_byte2: got d=%h s=%b e=%b q=%b want a2 0 0 1", out_data, out_sop, out_eop, out_qos);
        end
        idle(1);
        n_checks++;
        if ({out_data, out_sop, out_eop, out_qos} !== {8'hA3, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL basic_byte3: got d=%h s=%b e=%b q=%b want a3 0 1 1", out_data, out_sop, out_eop, out_qos);
        end
        idle(1);
        n_checks++;
        if (out_valid !== 1'b0 || pkt_ok_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_done: got valid=%b ok=%0d want 0 1", out_valid, pkt_ok_cnt);
        end
    endtask

    task automatic test_oversize();
        for (int i = 0; i < 9; i++)
            step(1, i == 0, i == 8, 0, 8'h10 + 8'(i), 1);
        n_checks++;
        if (out_valid !== 1'b0 || pkt_drop_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL oversize_drop: got valid=%b drop=%0d want 0 1", out_valid, pkt_drop_cnt);
        end
        step(1, 1, 0, 1, 8'h55, 1);
        step(1, 0, 1, 0, 8'h66, 1);
        repeat (3) idle(1);
        n_checks++;
        if (pkt_ok_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL oversize_next_ok: got %0d want 2", pkt_ok_cnt);
        end
    endtask

    task automatic test_overflow();
        int bytes, sops, eops;
        for (int p = 0; p < 5; p++)
            for (int i = 0; i < 4; i++)
                step(1, i == 0, i == 3, p[0], 8'(p * 16 + i), 0);
        n_checks++;
        if (pkt_ok_cnt !== 16'd6 || pkt_drop_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL overflow_counts: got ok=%0d drop=%0d want 6 2", pkt_ok_cnt, pkt_drop_cnt);
        end
        bytes = 0; sops = 0; eops = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                bytes++;
                sops += int'(out_sop);
                eops += int'(out_eop);
            end
            idle(1);
        end
        n_checks++;
        if (bytes != 16 || sops != 4 || eops != 4) begin
            n_fail++;
            $display("FAIL overflow_drain: got bytes=%0d sop=%0d eop=%0d want 16 4 4", bytes, sops, eops);
        end
    endtask

    task automatic test_sop_abort_orphan();
        step(1, 1, 0, 0, 8'hB1, 1);
        step(1, 1, 0, 1, 8'hC1, 1);
        step(1, 0, 1, 0, 8'hC2, 1);
        repeat (3) idle(1);
        n_checks++;
        if (pkt_drop_cnt !== 16'd3 || pkt_ok_cnt !== 16'd7) begin
            n_fail++;
            $display("FAIL abort_counts: got ok=%0d drop=%0d want 7 3", pkt_ok_cnt, pkt_drop_cnt);
        end
        step(1, 0, 0, 0, 8'h77, 1);
        n_checks++;
        if (orphan_err !== 1'b1) begin
            n_fail++;
            $display("FAIL orphan_pulse: got %b want 1", orphan_err);
        end
        idle(1);
        n_checks++;
        if (orphan_err !== 1'b0) begin
            n_fail++;
            $display("FAIL orphan_clear: got %b want 0", orphan_err);
        end
    endtask

    task automatic test_commit_during_drain();
        step(1, 1, 0, 0, 8'hD1, 0);
        step(1, 0, 0, 0, 8'hD2, 0);
        step(1, 0, 1, 0, 8'hD3, 0);
        idle(0);
        step(1, 1, 1, 1, 8'hE1, 1);
        n_checks++;
        if (out_data !== 8'hD2 || out_sop !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_commit_head: got d=%h s=%b want d2 0", out_data, out_sop);
        end
        repeat (4) idle(1);
        n_checks++;
        if (pkt_ok_cnt !== 16'd9 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_commit_done: got ok=%0d valid=%b want 9 0", pkt_ok_cnt, out_valid);
        end
    endtask

    task automatic test_reset_midpacket();
        for (int p = 0; p < 2; p++) begin
            step(1, 1, 0, 1, 8'hF0 + 8'(p), 0);
            step(1, 0, 1, 1, 8'hF8 + 8'(p), 0);
        end
        step(1, 1, 0, 0, 8'h3C, 0);
        step(1, 0, 0, 0, 8'h3D, 0);
        @(negedge clk);
        rst_n = 1'b0;
        in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({out_valid, out_sop, out_eop, out_qos, out_data, pkt_ok_cnt, pkt_drop_cnt, orphan_err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b d=%h ok=%0d drop=%0d want all 0",
                     out_valid, out_data, pkt_ok_cnt, pkt_drop_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 1, 0, 8'h3E, 1);
        step(1, 1, 0, 1, 8'h41, 1);
        step(1, 0, 1, 0, 8'h42, 1);
        repeat (3) idle(1);
        n_checks++;
        if (pkt_ok_cnt !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_after: got ok=%0d valid=%b want 1 0", pkt_ok_cnt, out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 3) == 0,
                 1'($urandom), 8'($urandom), $urandom_range(0, 9) < 5);
        repeat (DEPTH + 4) idle(1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_packet();
        test_oversize();
        test_overflow();
        test_sop_abort_orphan();
        test_commit_during_drain();
        test_reset_midpacket();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
